// File: rtl/CPU_Types.sv
// Shared fetch-stage types: opcode constants, fetch FSM states and
// the bundle handed from fetch to decode.
package CPU_Types;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        REQUEST,
        HOLD,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } fetch_output_t;

endpackage

// File: rtl/cpu_fetch_predecode.sv
// Combinational predecode of one instruction word: jump class and
// sign-extended B/J immediates, shared by fetch and decode.
module cpu_fetch_predecode
    import CPU_Types::*;
(
    input  logic [31:0] i_word,
    output logic        o_is_jal,
    output logic        o_is_jump_conditional,
    output logic [31:0] o_B_imm,
    output logic [31:0] o_J_imm
);

    assign o_is_jal              = (i_word[6:0] == OPCODE_JAL);
    assign o_is_jump_conditional = (i_word[6:0] == OPCODE_BRANCH);

    assign o_B_imm = {{20{i_word[31]}}, i_word[7], i_word[30:25],
                      i_word[11:8], 1'b0};
    assign o_J_imm = {{12{i_word[31]}}, i_word[19:12], i_word[20],
                      i_word[30:21], 1'b0};

endmodule

// File: rtl/cpu_fetch.sv
// Instruction-fetch stage: one outstanding bus read, predictor-driven
// next PC, valid/ready handoff to decode and redirect flush.
module cpu_fetch
    import CPU_Types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    output logic        o_bus_request,
    output logic [31:0] o_bus_address,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bp_pc,
    output logic        o_bp_is_jal,
    output logic        o_bp_is_jump_conditional,
    output logic [31:0] o_bp_inst_B_imm,
    output logic [31:0] o_bp_inst_J_imm,
    input  logic [31:0] i_bp_pc_hint,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_next,
    input  logic        i_jump,
    input  logic [31:0] i_jump_pc
);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_inst;
    logic [31:0]   r_hold_pc;
    logic          w_capture;
    logic [31:0]   w_jump_pc;
    fetch_output_t w_out;

    assign w_jump_pc = i_jump_pc & 32'hFFFF_FFFC;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_capture    = 1'b0;
        unique case (r_state)
            REQUEST: begin
                if (i_jump) begin
                    w_pc_next    = w_jump_pc;
                    w_state_next = i_bus_ready ? REQUEST : DISCARD;
                end else if (i_bus_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (i_jump) begin
                    w_pc_next    = w_jump_pc;
                    w_state_next = REQUEST;
                end else if (i_ready) begin
                    w_pc_next    = i_bp_pc_hint & 32'hFFFF_FFFC;
                    w_state_next = REQUEST;
                end
            end
            DISCARD: begin
                if (i_jump) begin
                    w_pc_next = w_jump_pc;
                end
                if (i_bus_ready) begin
                    w_state_next = REQUEST;
                end
            end
            default: w_state_next = REQUEST;
        endcase
    end

    // Bus address only moves when a fresh request starts, so it stays
    // stable across a pending read even if the PC is redirected.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= REQUEST;
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_inst    <= 32'h0;
            r_hold_pc <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_state_next == REQUEST) begin
                r_addr <= w_pc_next;
            end
            if (w_capture) begin
                r_inst    <= i_bus_rdata;
                r_hold_pc <= r_pc;
            end
        end
    end

    assign o_bus_request = i_reset_n && (r_state != HOLD);
    assign o_bus_address = r_addr;
    assign o_valid       = (r_state == HOLD);

    assign w_out.instruction = r_inst;
    assign w_out.pc          = r_hold_pc;
    assign w_out.pc_next     = o_valid ? i_bp_pc_hint : 32'h0;

    assign o_instruction = w_out.instruction;
    assign o_pc          = w_out.pc;
    assign o_pc_next     = w_out.pc_next;
    assign o_bp_pc       = r_hold_pc;

    cpu_fetch_predecode u_predecode (
        .i_word                (r_inst),
        .o_is_jal              (o_bp_is_jal),
        .o_is_jump_conditional (o_bp_is_jump_conditional),
        .o_B_imm               (o_bp_inst_B_imm),
        .o_J_imm               (o_bp_inst_J_imm)
    );

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: the bench plays bus slave, predictor
// and decode, with hand-computed expectations.
module tb_cpu_fetch;

    logic        clk;
    logic        rst_n;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [31:0] bp_pc;
    logic        bp_jal;
    logic        bp_cond;
    logic [31:0] bp_b;
    logic [31:0] bp_j;
    logic [31:0] bp_hint;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        jump;
    logic [31:0] jump_pc;

    int checks   = 0;
    int failures = 0;

    cpu_fetch #(.RESET_PC(32'h0)) dut (
        .i_clock                  (clk),
        .i_reset_n                (rst_n),
        .o_bus_request            (bus_req),
        .o_bus_address            (bus_addr),
        .i_bus_ready              (bus_ready),
        .i_bus_rdata              (bus_rdata),
        .o_bp_pc                  (bp_pc),
        .o_bp_is_jal              (bp_jal),
        .o_bp_is_jump_conditional (bp_cond),
        .o_bp_inst_B_imm          (bp_b),
        .o_bp_inst_J_imm          (bp_j),
        .i_bp_pc_hint             (bp_hint),
        .o_valid                  (valid),
        .i_ready                  (ready),
        .o_instruction            (instr),
        .o_pc                     (pc),
        .o_pc_next                (pc_next),
        .i_jump                   (jump),
        .i_jump_pc                (jump_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Redirect while the bus completes: fetch restarts at target next cycle.
    task automatic redirect_now(input logic [31:0] target);
        jump      = 1'b1;
        jump_pc   = target;
        bus_ready = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        step();
        jump      = 1'b0;
        bus_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        bp_hint   = 32'h0;
        ready     = 1'b0;
        jump      = 1'b0;
        jump_pc   = 32'h0;
        #12;
        chk("rst_req", {31'h0, bus_req}, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pcnext", pc_next, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_req", {31'h0, bus_req}, 32'h1);
        chk("first_addr", bus_addr, 32'h0);

        step();
        step();
        chk("wait_req", {31'h0, bus_req}, 32'h1);
        chk("wait_addr", bus_addr, 32'h0);
        chk("wait_valid", {31'h0, valid}, 32'h0);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0013;
        step();
        bus_ready = 1'b0;
        bp_hint   = 32'h4;
        #1;
        chk("nop_valid", {31'h0, valid}, 32'h1);
        chk("nop_instr", instr, 32'h0000_0013);
        chk("nop_pc", pc, 32'h0);
        chk("nop_pcnext", pc_next, 32'h4);
        chk("hold_noreq", {31'h0, bus_req}, 32'h0);
        chk("nop_jal", {31'h0, bp_jal}, 32'h0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("nop_drop", {31'h0, valid}, 32'h0);
        chk("nop_nextaddr", bus_addr, 32'h4);
        chk("nop_nextreq", {31'h0, bus_req}, 32'h1);

        redirect_now(32'h100);
        chk("r100_addr", bus_addr, 32'h100);
        chk("r100_valid", {31'h0, valid}, 32'h0);
        bus_ready = 1'b1;
        bus_rdata = 32'h0080_006F;
        step();
        bus_ready = 1'b0;
        bp_hint   = 32'h108;
        #1;
        chk("jal_is_jal", {31'h0, bp_jal}, 32'h1);
        chk("jal_is_cond", {31'h0, bp_cond}, 32'h0);
        chk("jal_jimm", bp_j, 32'h8);
        chk("jal_bppc", bp_pc, 32'h100);
        chk("jal_pcnext", pc_next, 32'h108);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("jal_nextaddr", bus_addr, 32'h108);

        redirect_now(32'h200);
        bus_ready = 1'b1;
        bus_rdata = 32'hFE00_0EE3;
        step();
        bus_ready = 1'b0;
        bp_hint   = 32'h1FC;
        #1;
        chk("beq_is_cond", {31'h0, bp_cond}, 32'h1);
        chk("beq_is_jal", {31'h0, bp_jal}, 32'h0);
        chk("beq_bimm", bp_b, 32'hFFFF_FFFC);
        chk("beq_pc", pc, 32'h200);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("beq_nextaddr", bus_addr, 32'h1FC);

        redirect_now(32'h10);
        chk("r10_addr", bus_addr, 32'h10);
        jump    = 1'b1;
        jump_pc = 32'h400;
        step();
        jump = 1'b0;
        chk("disc_addr0", bus_addr, 32'h10);
        chk("disc_req0", {31'h0, bus_req}, 32'h1);
        step();
        chk("disc_addr1", bus_addr, 32'h10);
        chk("disc_valid1", {31'h0, valid}, 32'h0);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0013;
        step();
        bus_ready = 1'b0;
        chk("disc_valid2", {31'h0, valid}, 32'h0);
        chk("disc_newaddr", bus_addr, 32'h400);
        chk("disc_newreq", {31'h0, bus_req}, 32'h1);

        bus_ready = 1'b1;
        bus_rdata = 32'h0010_0093;
        step();
        bus_ready = 1'b0;
        bp_hint   = 32'h404;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", {31'h0, valid}, 32'h1);
            chk("stall_instr", instr, 32'h0010_0093);
            chk("stall_pc", pc, 32'h400);
            chk("stall_pcnext", pc_next, 32'h404);
            step();
        end
        jump    = 1'b1;
        jump_pc = 32'h80;
        ready   = 1'b1;
        step();
        jump  = 1'b0;
        ready = 1'b0;
        chk("flush_valid", {31'h0, valid}, 32'h0);
        chk("flush_addr", bus_addr, 32'h80);
        chk("flush_req", {31'h0, bus_req}, 32'h1);

        redirect_now(32'h103);
        chk("align_addr", bus_addr, 32'h100);

        jump    = 1'b1;
        jump_pc = 32'h500;
        step();
        jump_pc = 32'h602;
        step();
        jump = 1'b0;
        chk("disc2_addr", bus_addr, 32'h100);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        chk("disc2_newaddr", bus_addr, 32'h600);
        chk("disc2_valid", {31'h0, valid}, 32'h0);

        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'h0, bus_req}, 32'h0);
        chk("midrst_addr", bus_addr, 32'h0);
        chk("midrst_valid", {31'h0, valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
